// File: rtl/fpu_gen_pkg.sv
// Shared types and helpers for the parametrised floating-point add/subtract unit.
// FSM state encoding, one-hot status bit positions, width/bias helpers.
package fpu_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    localparam int ST_EXACT   = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_UNF     = 2;
    localparam int ST_INEXACT = 3;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int word_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fpu_gen_round.sv
// Combinational rounding, overflow/underflow detection, packing and status.
// Truncation by default; round-to-nearest-even when FPU_ROUND_NEAREST_EN is defined.
module fpu_gen_round
    import fpu_gen_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic                   sign_in,
    input  logic [EXP_W:0]         exp_in,
    input  logic [MAN_W+2:0]       mant_in,
    input  logic                   zero_in,
    input  logic                   unf_in,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out
);

    logic [MAN_W-1:0] man;
    logic [2:0]       grs;
    logic             inexact;
    logic             up;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W:0]   exp_r;

    assign man     = mant_in[MAN_W+2:3];
    assign grs     = mant_in[2:0];
    assign inexact = |grs;

`ifdef FPU_ROUND_NEAREST_EN
    assign up = grs[2] & (grs[1] | grs[0] | man[0]);
`else
    assign up = 1'b0;
`endif

    // A carry out of the stored mantissa means 1.11..1 rounded to 10.0: bump exp.
    assign man_sum = {1'b0, man} + {{MAN_W{1'b0}}, up};
    assign exp_r   = exp_in + {{EXP_W{1'b0}}, man_sum[MAN_W]};

    always_comb begin
        data_out   = '0;
        status_out = '0;
        if (zero_in) begin
            status_out[ST_EXACT] = 1'b1;
        end else if (unf_in) begin
            data_out           = {sign_in, {(EXP_W + MAN_W){1'b0}}};
            status_out[ST_UNF] = 1'b1;
        end else if (exp_r[EXP_W]) begin
            data_out           = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            status_out[ST_OVF] = 1'b1;
        end else begin
            data_out = {sign_in, exp_r[EXP_W-1:0], man_sum[MAN_W-1:0]};
            if (inexact) begin
                status_out[ST_INEXACT] = 1'b1;
            end else begin
                status_out[ST_EXACT] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_gen.sv
// Multi-cycle floating-point add/subtract, one operation in flight; optional macro FPU_ROUND_NEAREST_EN.
// Latency 4 + align shifts + norm left shifts; in_ready only in IDLE, result held until out_ready.
module fpu_gen
    import fpu_gen_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   op_A_in,
    input  logic [EXP_W+MAN_W:0]   op_B_in,
    input  logic                   op_sub,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int W        = word_width(EXP_W, MAN_W);
    localparam int DW       = MAN_W + 4;   // hidden + stored mantissa + guard/round/sticky
    localparam int EW       = EXP_W + 1;   // one spare bit to catch exponent overflow
    localparam int COLLAPSE = MAN_W + 2;

    state_e           state_q, state_d;
    logic             sign_big_q, sign_big_d, sign_sml_q, sign_sml_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [EXP_W-1:0] diff_q, diff_d;
    logic [DW-1:0]    big_q, big_d, sml_q, sml_d;
    logic [DW:0]      sum_q, sum_d;
    logic             res_sign_q, res_sign_d;
    logic             zero_q, zero_d, unf_q, unf_d;
    logic [W-1:0]     data_q, data_d;
    logic [3:0]       status_q, status_d;

    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [DW-1:0]    a_mant, b_mant;
    logic [W-1:0]     rnd_data;
    logic [3:0]       rnd_status;

    assign a_sign = op_A_in[W-1];
    assign b_sign = op_B_in[W-1] ^ op_sub;
    assign a_exp  = op_A_in[W-2 -: EXP_W];
    assign b_exp  = op_B_in[W-2 -: EXP_W];
    assign a_mant = (a_exp == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0], 3'b000};
    assign b_mant = (b_exp == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0], 3'b000};

    fpu_gen_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign_in   (res_sign_q),
        .exp_in    (exp_q),
        .mant_in   (sum_q[DW-2:0]),
        .zero_in   (zero_q),
        .unf_in    (unf_q),
        .data_out  (rnd_data),
        .status_out(rnd_status)
    );

    always_comb begin
        state_d    = state_q;
        sign_big_d = sign_big_q;
        sign_sml_d = sign_sml_q;
        exp_d      = exp_q;
        diff_d     = diff_q;
        big_d      = big_q;
        sml_d      = sml_q;
        sum_d      = sum_q;
        res_sign_d = res_sign_q;
        zero_d     = zero_q;
        unf_d      = unf_q;
        data_d     = data_q;
        status_d   = status_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (a_exp >= b_exp) begin
                        sign_big_d = a_sign;
                        sign_sml_d = b_sign;
                        exp_d      = {1'b0, a_exp};
                        diff_d     = a_exp - b_exp;
                        big_d      = a_mant;
                        sml_d      = b_mant;
                    end else begin
                        sign_big_d = b_sign;
                        sign_sml_d = a_sign;
                        exp_d      = {1'b0, b_exp};
                        diff_d     = b_exp - a_exp;
                        big_d      = b_mant;
                        sml_d      = a_mant;
                    end
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (diff_q == '0) begin
                    state_d = S_ADD;
                end else if (int'(diff_q) > COLLAPSE) begin
                    // Every bit would fall below sticky anyway: skip the shifting.
                    sml_d   = {{(DW-1){1'b0}}, |sml_q};
                    diff_d  = '0;
                    state_d = S_ADD;
                end else begin
                    sml_d  = {1'b0, sml_q[DW-1:2], |sml_q[1:0]};
                    diff_d = diff_q - EXP_W'(1);
                end
            end
            S_ADD: begin
                zero_d = 1'b0;
                unf_d  = 1'b0;
                if (sign_big_q == sign_sml_q) begin
                    sum_d      = {1'b0, big_q} + {1'b0, sml_q};
                    res_sign_d = sign_big_q;
                end else if (big_q >= sml_q) begin
                    sum_d      = {1'b0, big_q - sml_q};
                    res_sign_d = sign_big_q;
                end else begin
                    sum_d      = {1'b0, sml_q - big_q};
                    res_sign_d = sign_sml_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                state_d = S_ROUND;
                if (sum_q[DW]) begin
                    sum_d = {1'b0, sum_q[DW:2], |sum_q[1:0]};
                    exp_d = exp_q + EW'(1);
                end else if (sum_q == '0) begin
                    zero_d = 1'b1;
                end else if (!sum_q[DW-1]) begin
                    if (exp_q <= EW'(1)) begin
                        unf_d = 1'b1;
                    end else begin
                        sum_d   = {sum_q[DW-1:0], 1'b0};
                        exp_d   = exp_q - EW'(1);
                        state_d = S_NORM;
                    end
                end
            end
            S_ROUND: begin
                data_d   = rnd_data;
                status_d = rnd_status;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sign_big_q <= 1'b0;
            sign_sml_q <= 1'b0;
            exp_q      <= '0;
            diff_q     <= '0;
            big_q      <= '0;
            sml_q      <= '0;
            sum_q      <= '0;
            res_sign_q <= 1'b0;
            zero_q     <= 1'b0;
            unf_q      <= 1'b0;
            data_q     <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            sign_big_q <= sign_big_d;
            sign_sml_q <= sign_sml_d;
            exp_q      <= exp_d;
            diff_q     <= diff_d;
            big_q      <= big_d;
            sml_q      <= sml_d;
            sum_q      <= sum_d;
            res_sign_q <= res_sign_d;
            zero_q     <= zero_d;
            unf_q      <= unf_d;
            data_q     <= data_d;
            status_q   <= status_d;
        end
    end

    assign data_out   = data_q;
    assign status_out = status_q;
    assign out_valid  = (state_q == S_DONE);
    assign in_ready   = (state_q == S_IDLE);

endmodule

// File: tb/tb_fpu_gen.sv
// Directed bench for fpu_gen at default widths (1/6/25): results, status, latency, reset and hold.
module tb_fpu_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b, dout;
    logic [3:0]  st;
    logic        op_sub, in_valid, in_ready, out_valid, out_ready;

    int checks = 0;
    int passed = 0;

    localparam logic [3:0] EXACT   = 4'b0001;
    localparam logic [3:0] OVF     = 4'b0010;
    localparam logic [3:0] UNF     = 4'b0100;
    localparam logic [3:0] INEXACT = 4'b1000;

    always #5 clk = ~clk;

    fpu_gen #(.EXP_W(6), .MAN_W(25)) dut (
        .clock100KHz(clk),
        .reset      (rst),
        .op_A_in    (op_a),
        .op_B_in    (op_b),
        .op_sub     (op_sub),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (dout),
        .status_out (st),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    function automatic logic [31:0] mk(input logic s, input logic [5:0] e, input logic [24:0] m);
        return {s, e, m};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (dout !== 32'h0) $display("FAIL reset_data got %h want 0", dout); else passed++;
        checks++; if (st !== 4'h0) $display("FAIL reset_status got %b want 0000", st); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_equal_exp();
        int lat;
        start_op(mk(0, 31, 0), mk(0, 31, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) $display("FAIL eq_latency got %0d want 4", lat); else passed++;
        checks++; if (dout !== mk(0, 32, 0)) $display("FAIL eq_data got %h want %h", dout, mk(0, 32, 0)); else passed++;
        checks++; if (st !== EXACT) $display("FAIL eq_status got %b want %b", st, EXACT); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL eq_in_ready_busy got %b want 0", in_ready); else passed++;
        accept();
        checks++; if (out_valid !== 1'b0) $display("FAIL eq_out_valid_after got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL eq_in_ready_after got %b want 1", in_ready); else passed++;
        checks++; if (dout !== mk(0, 32, 0)) $display("FAIL eq_data_held got %h want %h", dout, mk(0, 32, 0)); else passed++;
    endtask

    task automatic test_cancel_and_sub();
        int lat;
        start_op(mk(0, 31, 0), mk(1, 31, 0), 1'b0);
        wait_done(lat);
        checks++; if (dout !== 32'h0) $display("FAIL cancel_data got %h want 0", dout); else passed++;
        checks++; if (st !== EXACT) $display("FAIL cancel_status got %b want %b", st, EXACT); else passed++;
        accept();
        start_op(mk(0, 31, 0), mk(1, 31, 0), 1'b1);
        wait_done(lat);
        checks++; if (dout !== mk(0, 32, 0)) $display("FAIL sub_data got %h want %h", dout, mk(0, 32, 0)); else passed++;
        checks++; if (st !== EXACT) $display("FAIL sub_status got %b want %b", st, EXACT); else passed++;
        accept();
    endtask

    task automatic test_norm();
        int lat;
        // 2^31 - 2^30: one align shift, one left shift
        start_op(mk(0, 31, 0), mk(1, 30, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 6) $display("FAIL norm_left_latency got %0d want 6", lat); else passed++;
        checks++; if (dout !== mk(0, 30, 0)) $display("FAIL norm_left_data got %h want %h", dout, mk(0, 30, 0)); else passed++;
        checks++; if (st !== EXACT) $display("FAIL norm_left_status got %b want %b", st, EXACT); else passed++;
        accept();
        // carry-out drops the lsb into guard: a tie, even lsb, so both builds give {0,32,0}
        start_op(mk(0, 31, 1), mk(0, 31, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) $display("FAIL carry_latency got %0d want 4", lat); else passed++;
        checks++; if (dout !== mk(0, 32, 0)) $display("FAIL carry_data got %h want %h", dout, mk(0, 32, 0)); else passed++;
        checks++; if (st !== INEXACT) $display("FAIL carry_status got %b want %b", st, INEXACT); else passed++;
        accept();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(mk(0, 63, 25'h1FFFFFF), mk(0, 63, 25'h1FFFFFF), 1'b0);
        wait_done(lat);
        checks++; if (dout !== mk(0, 63, 25'h1FFFFFF)) $display("FAIL ovf_data got %h want %h", dout, mk(0, 63, 25'h1FFFFFF)); else passed++;
        checks++; if (st !== OVF) $display("FAIL ovf_status got %b want %b", st, OVF); else passed++;
        accept();
    endtask

    task automatic test_underflow();
        int lat;
        start_op(mk(0, 1, 1), mk(1, 1, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) $display("FAIL unf_latency got %0d want 4", lat); else passed++;
        checks++; if (dout !== 32'h0) $display("FAIL unf_data got %h want 0", dout); else passed++;
        checks++; if (st !== UNF) $display("FAIL unf_status got %b want %b", st, UNF); else passed++;
        accept();
        start_op(mk(1, 1, 1), mk(0, 1, 0), 1'b0);
        wait_done(lat);
        checks++; if (dout !== 32'h80000000) $display("FAIL unf_neg_data got %h want 80000000", dout); else passed++;
        checks++; if (st !== UNF) $display("FAIL unf_neg_status got %b want %b", st, UNF); else passed++;
        accept();
    endtask

    task automatic test_align();
        int lat;
        logic [31:0] want;
`ifdef FPU_ROUND_NEAREST_EN
        want = mk(0, 31, 2);
`else
        want = mk(0, 31, 1);
`endif
        start_op(mk(0, 31, 1), mk(0, 5, 0), 1'b0);
        // a new request while busy must be ignored
        op_a = mk(0, 10, 0); op_b = mk(0, 10, 0); in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) $display("FAIL align_busy_in_ready got %b want 0", in_ready); else passed++;
        wait_done(lat);
        lat = lat + 3;
        checks++; if (lat !== 30) $display("FAIL align26_latency got %0d want 30", lat); else passed++;
        checks++; if (dout !== want) $display("FAIL align26_data got %h want %h", dout, want); else passed++;
        checks++; if (st !== INEXACT) $display("FAIL align26_status got %b want %b", st, INEXACT); else passed++;
        accept();
        // diff 27: the largest shift still done bit by bit
        start_op(mk(0, 32, 0), mk(0, 5, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 31) $display("FAIL align27_latency got %0d want 31", lat); else passed++;
        checks++; if (dout !== mk(0, 32, 0)) $display("FAIL align27_data got %h want %h", dout, mk(0, 32, 0)); else passed++;
        checks++; if (st !== INEXACT) $display("FAIL align27_status got %b want %b", st, INEXACT); else passed++;
        accept();
        // diff 35 collapses to sticky in one cycle
        start_op(mk(0, 40, 0), mk(0, 5, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) $display("FAIL collapse_latency got %0d want 4", lat); else passed++;
        checks++; if (dout !== mk(0, 40, 0)) $display("FAIL collapse_data got %h want %h", dout, mk(0, 40, 0)); else passed++;
        checks++; if (st !== INEXACT) $display("FAIL collapse_status got %b want %b", st, INEXACT); else passed++;
        accept();
    endtask

    task automatic test_reset_mid_and_hold();
        int  lat;
        logic stable;
        start_op(mk(0, 31, 1), mk(0, 5, 0), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (dout !== 32'h0) $display("FAIL rstmid_data got %h want 0", dout); else passed++;
        checks++; if (st !== 4'h0) $display("FAIL rstmid_status got %b want 0000", st); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        start_op(mk(0, 31, 0), mk(0, 31, 0), 1'b0);
        wait_done(lat);
        checks++; if (lat !== 4) $display("FAIL post_rst_latency got %0d want 4", lat); else passed++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || dout !== mk(0, 32, 0) || st !== EXACT) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) $display("FAIL hold_stable got %b want 1 (data %h)", stable, dout); else passed++;
        accept();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(mk(0, 31, 0), mk(0, 31, 0), 1'b0);
        wait_done(lat);
        // request and result handshake on the same edge: request must wait a cycle
        op_a = mk(0, 31, 0); op_b = mk(1, 30, 0); op_sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_out_valid got %b want 0", out_valid); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(lat);
        checks++; if (lat !== 6) $display("FAIL b2b_latency got %0d want 6", lat); else passed++;
        checks++; if (dout !== mk(0, 30, 0)) $display("FAIL b2b_data got %h want %h", dout, mk(0, 30, 0)); else passed++;
        accept();
    endtask

    initial begin
        rst = 1'b1; op_a = '0; op_b = '0; op_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_equal_exp();
        test_cancel_and_sub();
        test_norm();
        test_overflow();
        test_underflow();
        test_align();
        test_reset_mid_and_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fpu_gen.md
# fpu_gen

Parametrised, multi-cycle floating-point add/subtract unit; the next generation of the team's fixed 32-bit (1/6/25) FPU. Field widths are set by parameters. Operations are add or subtract, selected per request. The unit uses valid/ready handshakes on both input and output and reports a one-hot status. It sits between the operand registers and the result bus of the datapath, one operation in flight at a time.

## Interface
- `EXP_W`, default 6, exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 25, stored mantissa width; hidden 1 is implicit.
- Word width W = 1+EXP_W+MAN_W, packed {sign, exp, man}.
- `clock100KHz`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op_A_in`  in  W  operand A.
- `op_B_in`  in  W  operand B.
- `op_sub`  in  1  0: A+B, 1: A−B (B sign inverted at accept).
- `in_valid`  in  1  request present.
- `in_ready`  out  1  high only in IDLE.
- `data_out`  out  W  result.
- `status_out`  out  4  one-hot: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.

## Operation
- Encoding: exp==0 means zero, whatever the mantissa bits. No denormals, inf or NaN. All-ones exp is an ordinary normal exponent.
- Accept on rising edge with in_valid && in_ready. Operands and op_sub are registered at that edge; later input changes are ignored.
- FSM: IDLE → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
- ALIGN:
  - Smaller-exponent operand is right-shifted 1 bit per cycle into a datapath of MAN_W+1 bits plus guard/round/sticky; exponent diff is decremented each cycle.
  - If the initial diff > MAN_W+2, the shifted mantissa collapses to sticky in one cycle.
  - Exits when diff==0.
- ADD: signed-magnitude add or subtract; the larger magnitude sets the sign.
- NORM:
  - On carry-out: one right shift and exp+1, in the first NORM cycle.
  - Otherwise: left shift 1 per cycle, exp−1, until the hidden bit is set.
- ROUND: truncation by default (see Configuration). Packs the result and computes status.
- Exact zero (x−x, or both inputs zero): data_out = all zeros (+0), EXACT.
- Overflow, when the final exp exceeds 2^EXP_W−1: data_out = {sign, all-ones exp, all-ones man}, OVERFLOW.
- Underflow, when normalization would take exp below 1: flush to {sign, 0, 0}, UNDERFLOW. NORM stops immediately.
- INEXACT: any nonzero discarded bit, with no over/underflow.
- EXACT: all other cases.
- DONE: out_valid=1. Leaves to IDLE on out_valid && out_ready.
- data_out/status_out hold the last result after handshake until the next ROUND.

## Timing
- Reset values: data_out=0, status_out=0, out_valid=0, in_ready=1, FSM=IDLE.
- Reset asserted mid-operation aborts the operation; the result is discarded.
- Latency from accept edge to out_valid: 4 + s + n cycles.
  - s = exp diff if diff ≤ MAN_W+2, else 0.
  - n = number of NORM left shifts.
  - Minimum is 4 (equal exponents, no normalization).
- out_ready held high in DONE: the result is accepted that edge; in_ready rises the next cycle. No accept in the same cycle as the result handshake.
- in_valid while busy: ignored, not queued.

## Configuration
- `FPU_ROUND_NEAREST_EN` defined:
  - ROUND applies round-to-nearest-even on guard/round/sticky.
  - A mantissa carry from rounding increments exp, in the same cycle; that increment can trigger OVERFLOW.
  - Latency is unchanged.
- Undefined: truncation toward zero.
- Status rules are identical in both builds (INEXACT = discarded bits nonzero).

## Structure
- Package `fpu_gen_pkg`: FSM state enum; status bit index constants (ST_EXACT=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3); bias/width helper functions.
- Sub-module `fpu_gen_round`: combinational rounding, overflow/underflow detection, packing and status. The only place the macro is referenced.

## Test plan
Default parameters; fields listed as {s,e,m}.
- {0,31,0}+{0,31,0}, op_sub=0 → {0,32,0}, EXACT, out_valid 4 cycles after accept.
- {0,31,0}+{1,31,0} → all zeros, EXACT; same operands with op_sub=1 → {0,32,0}.
- {0,63,all 1s}+{0,63,all 1s} → {0,63,all 1s}, OVERFLOW.
- {0,1,1}+{1,1,0} → {0,0,0}, UNDERFLOW; NORM aborts on exp limit.
- {0,31,1}+{0,5,0} → truncate build {0,31,1}, INEXACT; FPU_ROUND_NEAREST_EN build {0,31,2}, INEXACT; out_valid at 30 cycles.
- Reset pulse during ALIGN of a long shift → all outputs at reset values, in_ready=1. Next op {0,31,0}+{0,31,0} → {0,32,0}. out_ready held low 10 cycles → out_valid and data stable throughout.
